// File: rtl/fifo_rd_stream.sv
// Read-side stream adapter: pops words from an asynchronous-read FIFO
// into a two-entry registered skid buffer and presents them on a
// valid/ready interface. The pop strobe depends only on registered
// occupancy, so there is no combinational path from m_ready_i to fifo_rd_o.
module fifo_rd_stream #(
  parameter int WordLength = 8,
  parameter int CntBits    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  logic [WordLength-1:0] fifo_rd_data_i,
  output logic                  fifo_rd_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [WordLength-1:0] m_data_o,
  output logic [1:0]            level_o,
  output logic [CntBits-1:0]    xfer_cnt_o
);

  // The buffer state is its occupancy: the number of valid words held.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [WordLength-1:0] slot0_q, slot0_d;
  logic [WordLength-1:0] slot1_q, slot1_d;
  logic [CntBits-1:0]    xfer_q, xfer_d;
  logic                  pop;
  logic                  drain;

  // Pop whenever there is room, based on registered occupancy only.
  assign pop        = !fifo_empty_i && (state_q != S_TWO) && !flush_i;
  assign drain      = (state_q != S_EMPTY) && m_ready_i;
  assign fifo_rd_o  = pop;
  assign m_valid_o  = (state_q != S_EMPTY);
  assign m_data_o   = slot0_q;
  assign level_o    = state_q;
  assign xfer_cnt_o = xfer_q;

  // Next-state: occupancy transitions, slot shifting and transfer count.
  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    xfer_d  = xfer_q + {{(CntBits-1){1'b0}}, drain};
    if (flush_i) begin
      // Buffered words are dropped; slot contents are left as they are.
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (pop) begin
            slot0_d = fifo_rd_data_i;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (pop && drain) begin
            slot0_d = fifo_rd_data_i;
          end else if (pop) begin
            slot1_d = fifo_rd_data_i;
            state_d = S_TWO;
          end else if (drain) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          // No pop is possible here, so a drain just shifts the skid word up.
          if (drain) begin
            slot0_d = slot1_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // State and data registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      xfer_q  <= xfer_d;
    end
  end

endmodule
